// File: rtl/rom_lookup_arbiter.sv
// Round-robin arbiter sharing one 16x1 combinational ROM between NREQ requesters.
// Only one lookup is in flight; the bit returns on a per-requester valid/ready channel.
module rom_lookup_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [3:0]        rom_addr,
  input  logic              rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_r;
  state_t          state_nx_s;
  logic [IDXW-1:0] rr_ptr_r;
  logic [IDXW-1:0] owner_r;
  logic [IDXW-1:0] grant_idx_s;
  logic [IDXW-1:0] cand_idx_s;
  logic [IDXW-1:0] next_ptr_s;
  logic [IDXW:0]   cand_sum_s;
  logic            grant_found_s;
  logic            grant_s;

  // Rotating search; walking offsets downward leaves the nearest-to-pointer winner last.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_sum_s    = '0;
    cand_idx_s    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_sum_s    = {1'b0, rr_ptr_r} + (IDXW+1)'(i);
      cand_idx_s    = (cand_sum_s >= (IDXW+1)'(NREQ)) ?
                      IDXW'(cand_sum_s - (IDXW+1)'(NREQ)) : IDXW'(cand_sum_s);
      grant_idx_s   = req_valid[cand_idx_s] ? cand_idx_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_idx_s];
    end
  end

  assign grant_s    = (state_r == IDLE) && grant_found_s && !rst;
  assign next_ptr_s = (grant_idx_s == IDXW'(NREQ - 1)) ? '0 : grant_idx_s + IDXW'(1);
  assign req_ready  = grant_s ? (ONE_HOT0 << grant_idx_s) : '0;

  // Next-state selection for the IDLE -> READ -> RESP lookup sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_nx_s = READ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ: state_nx_s = RESP;
      RESP: begin
        if (rsp_ready[owner_r]) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, pointer, ROM address and response registers; reset aborts any lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      rom_addr  <= 4'd0;
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            rom_addr <= req_addr[{grant_idx_s, 2'b00} +: 4];
            owner_r  <= grant_idx_s;
            rr_ptr_r <= next_ptr_s;
          end
        end
        READ: begin
          rsp_data  <= rom_data;
          rsp_valid <= ONE_HOT0 << owner_r;
        end
        RESP: begin
          if (rsp_ready[owner_r]) begin
            rsp_valid <= '0;
          end
        end
        default: begin
          rsp_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Directed self-checking bench for rom_lookup_arbiter with a 16x1 ROM model (INIT 16'hABCD).
// Inputs are driven on the falling edge; outputs are checked 1 time unit later.
module tb_rom_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic        rsp_data;
  logic [3:0]  rsp_ready;
  logic [3:0]  rom_addr;
  logic        rom_data;
  logic        busy;

  logic [15:0] rom_init = 16'hABCD;
  int total = 0;
  int bad   = 0;

  // Hand-decoded ROM contents, index = address
  bit sweep_exp [0:15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit rr_exp [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  assign rom_data = rom_init[rom_addr];

  rom_lookup_arbiter #(.NREQ(4), .IDXW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One full lookup: handshake cycle, READ cycle, 'stall' held RESP cycles, accept cycle.
  task automatic do_lookup(input logic [3:0] vmask, input int k, input logic [3:0] a,
                           input logic exp_d, input int stall);
    logic [3:0] kbit;
    kbit = 4'b0001 << k;
    cyc();
    req_valid = vmask;
    req_addr[4*k +: 4] = a;
    rsp_ready = 4'b0000;
    #1;
    check_eq("grant", 32'(req_ready), 32'(kbit));
    check_eq("grant_busy", 32'(busy), 32'(0));
    check_eq("grant_rspv", 32'(rsp_valid), 32'(0));
    cyc();
    req_valid = vmask & ~kbit;
    #1;
    check_eq("read_busy", 32'(busy), 32'(1));
    check_eq("read_addr", 32'(rom_addr), 32'(a));
    check_eq("read_rdy", 32'(req_ready), 32'(0));
    check_eq("read_rspv", 32'(rsp_valid), 32'(0));
    for (int s = 0; s < stall; s++) begin
      cyc();
      rsp_ready = (s % 2 == 0) ? ~kbit : 4'b0000;
      #1;
      check_eq("stall_rspv", 32'(rsp_valid), 32'(kbit));
      check_eq("stall_data", 32'(rsp_data), 32'(exp_d));
      check_eq("stall_rdy", 32'(req_ready), 32'(0));
    end
    cyc();
    rsp_ready = kbit;
    #1;
    check_eq("resp_rspv", 32'(rsp_valid), 32'(kbit));
    check_eq("resp_data", 32'(rsp_data), 32'(exp_d));
    check_eq("resp_rdy", 32'(req_ready), 32'(0));
  endtask

  task automatic idle_check();
    cyc();
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    #1;
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_rspv", 32'(rsp_valid), 32'(0));
    check_eq("idle_rdy", 32'(req_ready), 32'(0));
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    req_addr = 16'h0000;
    rsp_ready = 4'b0000;

    // Reset values, and no grant while rst is high
    cyc();
    cyc();
    #1;
    check_eq("rst_rdy", 32'(req_ready), 32'(0));
    cyc();
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    check_eq("rst_addr", 32'(rom_addr), 32'(0));
    check_eq("rst_rspv", 32'(rsp_valid), 32'(0));
    check_eq("rst_data", 32'(rsp_data), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_idle_rdy", 32'(req_ready), 32'(0));

    // First lookup: req0 address 0
    do_lookup(4'b0001, 0, 4'd0, 1'b1, 0);
    idle_check();

    // Address sweep from req2, one grant every 3 cycles
    for (int a = 0; a < 16; a++) begin
      do_lookup(4'b0100, 2, 4'(a), sweep_exp[a], 0);
    end
    idle_check();

    // Round robin with everybody requesting
    do_reset();
    req_addr = 16'h7654;
    for (int g = 0; g < 8; g++) begin
      do_lookup(4'b1111, g % 4, 4'(4 + (g % 4)), rr_exp[g % 4], 0);
    end
    idle_check();

    // Backpressure on req1, req3 waiting then granted right after RESP exits
    do_lookup(4'b1010, 1, 4'd12, 1'b0, 5);
    do_lookup(4'b1000, 3, 4'd7, 1'b1, 0);
    idle_check();

    // Pointer wrap and rotation
    do_lookup(4'b0100, 2, 4'd3, 1'b1, 0);
    do_lookup(4'b0001, 0, 4'd1, 1'b0, 0);
    do_lookup(4'b0101, 2, 4'd9, 1'b1, 0);
    do_lookup(4'b1000, 3, 4'd14, 1'b0, 0);
    do_lookup(4'b1111, 0, 4'd2, 1'b1, 0);
    idle_check();

    // Abort during READ
    cyc();
    req_valid = 4'b0100;
    req_addr[11:8] = 4'd15;
    #1;
    check_eq("abort_grant", 32'(req_ready), 32'(4'b0100));
    cyc();
    rst = 1'b1;
    req_valid = 4'b0010;
    req_addr[7:4] = 4'd6;
    #1;
    check_eq("abort_busy", 32'(busy), 32'(1));
    check_eq("abort_addr", 32'(rom_addr), 32'(15));
    check_eq("abort_rdy", 32'(req_ready), 32'(0));
    cyc();
    rst = 1'b0;
    #1;
    check_eq("post_rspv", 32'(rsp_valid), 32'(0));
    check_eq("post_busy", 32'(busy), 32'(0));
    check_eq("post_addr", 32'(rom_addr), 32'(0));
    check_eq("post_grant", 32'(req_ready), 32'(4'b0010));
    cyc();
    req_valid = 4'b0000;
    #1;
    check_eq("post_read_addr", 32'(rom_addr), 32'(6));
    check_eq("post_read_rspv", 32'(rsp_valid), 32'(0));
    cyc();
    rsp_ready = 4'b0010;
    #1;
    check_eq("post_rspv1", 32'(rsp_valid), 32'(4'b0010));
    check_eq("post_data", 32'(rsp_data), 32'(1));
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
